iob_t2p_ram: RTL and testbench

- Synchronous two-port RAM with one independent write port and one independent read port.
- Both ports run in a single clock domain.
- Used as a generic storage primitive for FIFOs, buffers and register files.
- Parameter USE_RAM selects the read-port style:
  - 1: read enable gates the output register (BRAM-like).
  - 0: output register updates every cycle.

---
 rtl/iob_t2p_ram_pkg.sv | 22 ++
 rtl/iob_t2p_ram_if.sv | 26 ++
 rtl/iob_t2p_ram_rdreg.sv | 42 ++++
 rtl/iob_t2p_ram.sv | 52 +++++
 tb/tb_iob_t2p_ram.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/iob_t2p_ram_pkg.sv
// Shared constants, typedefs and helpers for the iob_t2p_ram two-port RAM.
package iob_t2p_ram_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ADDR_W = 4;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  localparam int unsigned DEFAULT_DEPTH = depth(DEFAULT_ADDR_W);

  typedef logic [DEFAULT_DATA_W-1:0] data_t;
  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

  // Read-port style: gated loads only on r_en, free loads every edge.
  typedef enum logic {
    RD_FREE  = 1'b0,
    RD_GATED = 1'b1
  } rd_mode_e;

endpackage

// File: rtl/iob_t2p_ram_if.sv
// Write/read port bundle for iob_t2p_ram; slave is the RAM, master the user.
interface iob_t2p_ram_if
  import iob_t2p_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] data_in;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] data_out;

  modport master (
    output w_en, w_addr, data_in, r_en, r_addr,
    input  data_out
  );

  modport slave (
    input  w_en, w_addr, data_in, r_en, r_addr,
    output data_out
  );

endinterface

// File: rtl/iob_t2p_ram_rdreg.sv
// Registered read port: sync reset, optional r_en gating, and write-first
// forwarding when IOB_T2P_RAM_BYPASS_EN is defined.
module iob_t2p_ram_rdreg
  import iob_t2p_ram_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned USE_RAM = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] mem_data,
`ifdef IOB_T2P_RAM_BYPASS_EN
  input  logic              fwd,
  input  logic [DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0] q
);

  localparam rd_mode_e MODE = (USE_RAM != 0) ? RD_GATED : RD_FREE;

  // Power-up value is zero so data_out is defined before the first reset.
  logic [DATA_W-1:0] q_r = '0;
  logic [DATA_W-1:0] q_nxt;
  logic              ld;

  always_comb begin
    ld    = (MODE == RD_FREE) || rd_req;
    q_nxt = mem_data;
`ifdef IOB_T2P_RAM_BYPASS_EN
    if (fwd) q_nxt = fwd_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)     q_r <= '0;
    else if (ld) q_r <= q_nxt;
  end

  assign q = q_r;

endmodule

// File: rtl/iob_t2p_ram.sv
// Synchronous two-port RAM (one write, one registered read port).
// Define IOB_T2P_RAM_BYPASS_EN for write-first behaviour on collisions.
module iob_t2p_ram
  import iob_t2p_ram_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned USE_RAM = 0
) (
  input  logic          clk,
  input  logic          rst,
  iob_t2p_ram_if.slave  bus
);

  localparam int unsigned DEPTH = depth(ADDR_W);

  // Storage is deliberately left out of reset so contents survive rst.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] rd_q;
  logic              rd_act;

  always_ff @(posedge clk) begin
    if (bus.w_en) mem[bus.w_addr] <= bus.data_in;
  end

  assign mem_rd = mem[bus.r_addr];
  assign rd_act = (USE_RAM != 0) ? bus.r_en : 1'b1;

`ifdef IOB_T2P_RAM_BYPASS_EN
  logic fwd;
  assign fwd = bus.w_en && rd_act && (bus.w_addr == bus.r_addr);
`endif

  iob_t2p_ram_rdreg #(
    .DATA_W  (DATA_W),
    .USE_RAM (USE_RAM)
  ) u_rdreg (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_act),
    .mem_data (mem_rd),
`ifdef IOB_T2P_RAM_BYPASS_EN
    .fwd      (fwd),
    .fwd_data (bus.data_in),
`endif
    .q        (rd_q)
  );

  assign bus.data_out = rd_q;

endmodule

// File: tb/tb_iob_t2p_ram.sv
// Scoreboard bench driving a gated (USE_RAM=1) and a free-running (USE_RAM=0) RAM in lockstep.
module tb_iob_t2p_ram;
  import iob_t2p_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  iob_t2p_ram_if #(.DATA_W(8), .ADDR_W(4)) bus_g ();
  iob_t2p_ram_if #(.DATA_W(8), .ADDR_W(4)) bus_f ();

  iob_t2p_ram #(.DATA_W(8), .ADDR_W(4), .USE_RAM(1)) u_gated (
    .clk (clk), .rst (rst), .bus (bus_g.slave)
  );
  iob_t2p_ram #(.DATA_W(8), .ADDR_W(4), .USE_RAM(0)) u_free (
    .clk (clk), .rst (rst), .bus (bus_f.slave)
  );

  typedef struct {
    data_t g;
    data_t f;
  } exp_t;

  exp_t  sb[$];
  data_t mdl_mem [16];
  data_t mdl_g = '0;
  data_t mdl_f = '0;
  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef IOB_T2P_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input data_t got, input data_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic data_t mdl_read(input addr_t ra, input logic we,
                                     input addr_t wa, input data_t din);
    if (BYPASS && we && (wa == ra)) return din;
    return mdl_mem[ra];
  endfunction

  // One clock: drive at negedge, predict, then compare 1 ns after posedge.
  task automatic cycle(input logic r, input logic we, input addr_t wa,
                       input data_t din, input logic re, input addr_t ra);
    exp_t e;
    data_t v;
    @(negedge clk);
    rst = r;
    bus_g.w_en = we; bus_g.w_addr = wa; bus_g.data_in = din;
    bus_g.r_en = re; bus_g.r_addr = ra;
    bus_f.w_en = we; bus_f.w_addr = wa; bus_f.data_in = din;
    bus_f.r_en = re; bus_f.r_addr = ra;
    v = mdl_read(ra, we, wa, din);
    if (r) begin
      mdl_g = '0;
      mdl_f = '0;
    end else begin
      if (re) mdl_g = v;
      mdl_f = v;
    end
    if (we) mdl_mem[wa] = din;
    e.g = mdl_g;
    e.f = mdl_f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 8'h00, 8'hff);
    end else begin
      e = sb.pop_front();
      check("sb_gated", bus_g.data_out, e.g);
      // Free port may legitimately read never-written words during the fill.
      if (!$isunknown(e.f)) check("sb_free", bus_f.data_out, e.f);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl_mem[i] = 'x;
    bus_g.w_en = 1'b0; bus_g.w_addr = '0; bus_g.data_in = '0;
    bus_g.r_en = 1'b0; bus_g.r_addr = '0;
    bus_f.w_en = 1'b0; bus_f.w_addr = '0; bus_f.data_in = '0;
    bus_f.r_en = 1'b0; bus_f.r_addr = '0;

    #1;
    check("pwr_gated", bus_g.data_out, 8'h00);
    check("pwr_free", bus_f.data_out, 8'h00);

    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    check("rst_gated", bus_g.data_out, 8'h00);
    check("rst_free", bus_f.data_out, 8'h00);

    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, addr_t'(i), data_t'(i + 32), 1'b0, addr_t'(i == 0 ? 0 : i - 1));
      check("fill_gated", bus_g.data_out, 8'h00);
    end

    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, addr_t'(i));
      check("noren_gated", bus_g.data_out, 8'h00);
      check("noren_free", bus_f.data_out, data_t'(i + 32));
    end

    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, addr_t'(i));
      check("sweep_gated", bus_g.data_out, data_t'(i + 32));
      check("sweep_free", bus_f.data_out, data_t'(i + 32));
    end

    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    check("pre_rst_g", bus_g.data_out, 8'd37);
    cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    check("mid_rst_g", bus_g.data_out, 8'h00);
    check("mid_rst_f", bus_f.data_out, 8'h00);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    check("post_rst_g", bus_g.data_out, 8'd37);
    check("post_rst_f", bus_f.data_out, 8'd37);

    cycle(1'b0, 1'b1, 4'd3, 8'hAA, 1'b1, 4'd3);
    check("coll_g", bus_g.data_out, BYPASS ? 8'hAA : 8'd35);
    check("coll_f", bus_f.data_out, BYPASS ? 8'hAA : 8'd35);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
    check("after_coll_g", bus_g.data_out, 8'hAA);
    check("after_coll_f", bus_f.data_out, 8'hAA);

    // Collision with the gated port idle must not disturb its held value.
    cycle(1'b0, 1'b1, 4'd3, 8'h55, 1'b0, 4'd3);
    check("coll_idle_g", bus_g.data_out, 8'hAA);

    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    check("hold_rd_g", bus_g.data_out, 8'd39);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd9);
    check("hold1_g", bus_g.data_out, 8'd39);
    check("hold1_f", bus_f.data_out, 8'd41);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd9);
    check("hold2_g", bus_g.data_out, 8'd39);

    check("sb_drained", data_t'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
